exe_stage: RTL and testbench

Execute stage of the five-stage RISC-V pipeline. Sits directly downstream of the ID/EX latch: it consumes the `*_exe` control, operand and immediate fields, performs ALU, branch and jump-target computation, and registers the result into the EX/MEM latch. The EX/MEM latch holds the data-memory request until `dhit`. The stage also generates the PC redirect and front-end flush for taken branches and jumps.

---
 rtl/exe_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_exe_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage of the five-stage RISC-V pipeline.
// It computes the ALU result, resolves branches and jumps, and registers
// the result into the EX/MEM latch. It also drives the PC redirect and the
// pipeline stall.
// Optional feature macro: EXE_FORWARD_EN. When it is defined, rs1/rs2 are
// forwarded from EX/MEM and from writeback.

package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_SRA  = 4'd2,
      ALU_ADD  = 4'd3,
      ALU_SUB  = 4'd4,
      ALU_AND  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;
endpackage

module exe_stage
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        flush_in,
   input  logic [31:0] imemaddr_exe,
   input  logic [31:0] imemload_exe,
   input  logic [31:0] rdat1_exe,
   input  logic [31:0] rdat2_exe,
   input  logic [31:0] imm_exe,
   input  aluop_t      alu_op_exe,
   input  logic        branch_exe,
   input  logic        jal_exe,
   input  logic        jalr_exe,
   input  logic        auipc_exe,
   input  logic        lui_exe,
   input  logic        ALUsrc_exe,
   input  logic        dmemr_exe,
   input  logic        dmemw_exe,
   input  logic        WEN_exe,
   input  logic        memtoreg_exe,
   input  logic        halt_exe,
   input  logic        wb_WEN,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        pc_redirect,
   output logic [31:0] redirect_target,
   output logic        stall,
   output logic [31:0] aluout_mem,
   output logic [31:0] storedata_mem,
   output logic [31:0] npc_mem,
   output logic [31:0] imemaddr_mem,
   output logic [4:0]  rd_mem,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic        WEN_mem,
   output logic        memtoreg_mem,
   output logic        jump_mem,
   output logic        halt_mem
);

   // ALU: the comparisons and the arithmetic shift are explicitly signed
   function automatic word_t alu_f(input aluop_t op, input word_t a, input word_t b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      word_t              r;
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = word_t'(sa >>> b[4:0]);
         ALU_SLT:  r = {31'd0, (sa < sb)};
         ALU_SLTU: r = {31'd0, (a < b)};
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         default:  r = '0;
      endcase
      return r;
   endfunction

   // Branch condition selected by funct3; unused encodings are never taken
   function automatic logic br_cond_f(input logic [2:0] f3, input word_t a, input word_t b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic               c;
      sa = a;
      sb = b;
      c  = 1'b0;
      case (f3)
         3'b000:  c = (a == b);
         3'b001:  c = (a != b);
         3'b100:  c = (sa < sb);
         3'b101:  c = (sa >= sb);
         3'b110:  c = (a < b);
         3'b111:  c = (a >= b);
         default: c = 1'b0;
      endcase
      return c;
   endfunction

   word_t       rs1_p0;
   word_t       rs2_p0;
   word_t       opa_p0;
   word_t       opb_p0;
   word_t       alu_p0;
   word_t       jalr_sum_p0;
   logic        cond_p0;
   logic        mem_busy;
   logic        advance;
   logic        unused_bits;

`ifdef EXE_FORWARD_EN
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;

   assign rs1_idx = imemload_exe[19:15];
   assign rs2_idx = imemload_exe[24:20];

   // Operand forwarding: a non-load EX/MEM result wins over writeback; x0 is never forwarded
   always_comb begin
      rs1_p0 = rdat1_exe;
      rs2_p0 = rdat2_exe;
      if (WEN_mem && !memtoreg_mem && (rd_mem == rs1_idx) && (rs1_idx != 5'd0))
         rs1_p0 = aluout_mem;
      else if (wb_WEN && (wb_rd == rs1_idx) && (rs1_idx != 5'd0))
         rs1_p0 = wb_data;
      if (WEN_mem && !memtoreg_mem && (rd_mem == rs2_idx) && (rs2_idx != 5'd0))
         rs2_p0 = aluout_mem;
      else if (wb_WEN && (wb_rd == rs2_idx) && (rs2_idx != 5'd0))
         rs2_p0 = wb_data;
   end

   assign unused_bits = ^{imemload_exe[31:25], imemload_exe[6:0]};
`else
   assign rs1_p0      = rdat1_exe;
   assign rs2_p0      = rdat2_exe;
   assign unused_bits = ^{imemload_exe[31:15], imemload_exe[6:0], wb_WEN, wb_rd, wb_data};
`endif

   // Operand selection and ALU evaluation for the instruction in EX
   always_comb begin
      opa_p0 = rs1_p0;
      if (auipc_exe)
         opa_p0 = imemaddr_exe;
      else if (lui_exe)
         opa_p0 = '0;
      opb_p0 = (ALUsrc_exe || lui_exe || auipc_exe) ? imm_exe : rs2_p0;
      alu_p0 = alu_f(alu_op_exe, opa_p0, opb_p0);
   end

   assign cond_p0     = br_cond_f(imemload_exe[14:12], rs1_p0, rs2_p0);
   assign jalr_sum_p0 = rs1_p0 + imm_exe;

   // An outstanding memory request holds the pipe until dhit; a halt freezes it for good
   assign mem_busy = (dmemREN || dmemWEN) && !dhit;
   assign stall    = !ihit || mem_busy;
   assign advance  = !stall && !halt_mem;

   // Redirect target: the jalr sum has its LSB cleared; branch and jal are PC-relative
   always_comb begin
      redirect_target = imemaddr_exe + imm_exe;
      if (jalr_exe)
         redirect_target = {jalr_sum_p0[31:1], 1'b0};
      pc_redirect = advance && (jal_exe || jalr_exe || (branch_exe && cond_p0));
   end

   // ---- EX -> MEM boundary: load, bubble, retire the one-shot request, or hold ----
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         aluout_mem    <= '0;
         storedata_mem <= '0;
         npc_mem       <= '0;
         imemaddr_mem  <= '0;
         rd_mem        <= '0;
         dmemREN       <= 1'b0;
         dmemWEN       <= 1'b0;
         WEN_mem       <= 1'b0;
         memtoreg_mem  <= 1'b0;
         jump_mem      <= 1'b0;
         halt_mem      <= 1'b0;
      end else if (advance) begin
         if (flush_in) begin
            aluout_mem    <= '0;
            storedata_mem <= '0;
            npc_mem       <= '0;
            imemaddr_mem  <= '0;
            rd_mem        <= '0;
            dmemREN       <= 1'b0;
            dmemWEN       <= 1'b0;
            WEN_mem       <= 1'b0;
            memtoreg_mem  <= 1'b0;
            jump_mem      <= 1'b0;
            halt_mem      <= 1'b0;
         end else begin
            aluout_mem    <= alu_p0;
            storedata_mem <= rs2_p0;
            npc_mem       <= imemaddr_exe + 32'd4;
            imemaddr_mem  <= imemaddr_exe;
            rd_mem        <= imemload_exe[11:7];
            dmemREN       <= dmemr_exe;
            dmemWEN       <= dmemw_exe;
            WEN_mem       <= WEN_exe;
            memtoreg_mem  <= memtoreg_exe;
            jump_mem      <= jal_exe || jalr_exe;
            halt_mem      <= halt_exe;
         end
      end else if (dhit && !halt_mem) begin
         dmemREN <= 1'b0;
         dmemWEN <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage. It keeps a transaction-level model of
// the EX/MEM latch and checks it on every falling edge. Directed vectors
// with literal expectations pin the model.
module tb_exe_stage;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit, dhit, flush_in;
   logic [31:0] imemaddr_exe, imemload_exe, rdat1_exe, rdat2_exe, imm_exe;
   aluop_t      alu_op_exe;
   logic        branch_exe, jal_exe, jalr_exe, auipc_exe, lui_exe, ALUsrc_exe;
   logic        dmemr_exe, dmemw_exe, WEN_exe, memtoreg_exe, halt_exe;
   logic        wb_WEN;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        pc_redirect, stall;
   logic [31:0] redirect_target, aluout_mem, storedata_mem, npc_mem, imemaddr_mem;
   logic [4:0]  rd_mem;
   logic        dmemREN, dmemWEN, WEN_mem, memtoreg_mem, jump_mem, halt_mem;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   exe_stage dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .flush_in(flush_in),
      .imemaddr_exe(imemaddr_exe), .imemload_exe(imemload_exe),
      .rdat1_exe(rdat1_exe), .rdat2_exe(rdat2_exe), .imm_exe(imm_exe),
      .alu_op_exe(alu_op_exe), .branch_exe(branch_exe), .jal_exe(jal_exe),
      .jalr_exe(jalr_exe), .auipc_exe(auipc_exe), .lui_exe(lui_exe),
      .ALUsrc_exe(ALUsrc_exe), .dmemr_exe(dmemr_exe), .dmemw_exe(dmemw_exe),
      .WEN_exe(WEN_exe), .memtoreg_exe(memtoreg_exe), .halt_exe(halt_exe),
      .wb_WEN(wb_WEN), .wb_rd(wb_rd), .wb_data(wb_data),
      .pc_redirect(pc_redirect), .redirect_target(redirect_target), .stall(stall),
      .aluout_mem(aluout_mem), .storedata_mem(storedata_mem), .npc_mem(npc_mem),
      .imemaddr_mem(imemaddr_mem), .rd_mem(rd_mem), .dmemREN(dmemREN),
      .dmemWEN(dmemWEN), .WEN_mem(WEN_mem), .memtoreg_mem(memtoreg_mem),
      .jump_mem(jump_mem), .halt_mem(halt_mem)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] alu, sd, npc, pc;
      logic [4:0]  rd;
      logic        ren, wen, w, mtr, j, halt;
   } lat_t;

   lat_t        m, fresh;
   logic [31:0] e_rs1, e_rs2, e_opa, e_opb, e_target;
   logic        e_taken, e_stall, e_adv, e_redir;

   function automatic logic [31:0] alu_model(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic logic taken_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] src_model(input logic [4:0] rs, input logic [31:0] rdat, input lat_t l,
                                             input logic wwen, input logic [4:0] wrd, input logic [31:0] wdat);
`ifdef EXE_FORWARD_EN
      if (rs != 0 && l.w && !l.mtr && l.rd == rs) return l.alu;
      if (rs != 0 && wwen && wrd == rs) return wdat;
`endif
      return rdat;
   endfunction

   always_comb begin
      e_rs1    = src_model(imemload_exe[19:15], rdat1_exe, m, wb_WEN, wb_rd, wb_data);
      e_rs2    = src_model(imemload_exe[24:20], rdat2_exe, m, wb_WEN, wb_rd, wb_data);
      e_opa    = auipc_exe ? imemaddr_exe : (lui_exe ? 32'd0 : e_rs1);
      e_opb    = (ALUsrc_exe || lui_exe || auipc_exe) ? imm_exe : e_rs2;
      e_taken  = taken_model(imemload_exe[14:12], e_rs1, e_rs2);
      e_target = jalr_exe ? ((e_rs1 + imm_exe) & 32'hFFFF_FFFE) : (imemaddr_exe + imm_exe);
      e_stall  = !ihit || ((m.ren || m.wen) && !dhit);
      e_adv    = !e_stall && !m.halt;
      e_redir  = e_adv && (jal_exe || jalr_exe || (branch_exe && e_taken));
      fresh    = '{alu: alu_model(alu_op_exe, e_opa, e_opb), sd: e_rs2,
                   npc: imemaddr_exe + 32'd4, pc: imemaddr_exe, rd: imemload_exe[11:7],
                   ren: dmemr_exe, wen: dmemw_exe, w: WEN_exe, mtr: memtoreg_exe,
                   j: jal_exe || jalr_exe, halt: halt_exe};
   end

   always @(posedge CLK or posedge RST) begin
      if (RST)          m <= '0;
      else if (m.halt)  m <= m;
      else if (e_adv)   m <= flush_in ? '0 : fresh;
      else if (dhit) begin
         m.ren <= 1'b0;
         m.wen <= 1'b0;
      end
   end

   // compare process
   always @(negedge CLK) begin
      chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, e_redir});
      chk("redirect_target", redirect_target, e_target);
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("aluout_mem", aluout_mem, m.alu);
      chk("storedata_mem", storedata_mem, m.sd);
      chk("npc_mem", npc_mem, m.npc);
      chk("imemaddr_mem", imemaddr_mem, m.pc);
      chk("rd_mem", {27'd0, rd_mem}, {27'd0, m.rd});
      chk("ctrl_mem", {26'd0, dmemREN, dmemWEN, WEN_mem, memtoreg_mem, jump_mem, halt_mem},
          {26'd0, m.ren, m.wen, m.w, m.mtr, m.j, m.halt});
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3);
      return {7'd0, rs2, rs1, f3, rd, 7'h33};
   endfunction

   task automatic clr();
      ihit = 1'b1; dhit = 1'b0; flush_in = 1'b0;
      imemaddr_exe = '0; imemload_exe = '0; rdat1_exe = '0; rdat2_exe = '0; imm_exe = '0;
      alu_op_exe = ALU_ADD;
      branch_exe = 0; jal_exe = 0; jalr_exe = 0; auipc_exe = 0; lui_exe = 0; ALUsrc_exe = 0;
      dmemr_exe = 0; dmemw_exe = 0; WEN_exe = 0; memtoreg_exe = 0; halt_exe = 0;
      wb_WEN = 0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic alu(input aluop_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      alu_op_exe = op; rdat1_exe = a; rdat2_exe = b; imemload_exe = mk(rd, 0, 0, 0); WEN_exe = 1'b1;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      clr();
      RST = 1'b1;
      ihit = 1'b0;
      #1 chk("rst_stall_ihit0", {31'd0, stall}, 32'd1);
      ihit = 1'b1;
      #1 chk("rst_stall_ihit1", {31'd0, stall}, 32'd0);
      chk("rst_aluout", aluout_mem, 32'd0);
      chk("rst_halt", {31'd0, halt_mem}, 32'd0);
      step();
      RST = 1'b0;

      // ALU
      clr(); alu(ALU_SUB, 32'h0, 32'h1, 5'd3); step();
      chk("sub", aluout_mem, 32'hFFFF_FFFF);
      chk("sub_rd", {27'd0, rd_mem}, 32'd3);
      clr(); alu(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd4); step();
      chk("slt", aluout_mem, 32'd1);
      clr(); alu(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd4); step();
      chk("sltu", aluout_mem, 32'd0);
      clr(); alu(ALU_SRA, 32'h8000_0000, 32'd4, 5'd4); step();
      chk("sra", aluout_mem, 32'hF800_0000);
      clr(); alu(ALU_ADD, 32'd10, 32'd99, 5'd4); ALUsrc_exe = 1; imm_exe = 32'd5; step();
      chk("addi", aluout_mem, 32'd15);
      clr(); alu(ALU_ADD, 32'd7, 32'd7, 5'd4); lui_exe = 1; imm_exe = 32'h1234_5000; step();
      chk("lui", aluout_mem, 32'h1234_5000);
      clr(); alu(ALU_ADD, 32'd7, 32'd7, 5'd4); auipc_exe = 1; imemaddr_exe = 32'h40; imm_exe = 32'h1000; step();
      chk("auipc", aluout_mem, 32'h1040);

      // branches and jumps
      clr(); imemaddr_exe = 32'h100; imemload_exe = mk(0, 0, 0, 3'b000);
      rdat1_exe = 32'h55; rdat2_exe = 32'h55; imm_exe = 32'h20; branch_exe = 1;
      #1 chk("beq_redirect", {31'd0, pc_redirect}, 32'd1);
      chk("beq_target", redirect_target, 32'h120);
      step();
      chk("beq_npc", npc_mem, 32'h104);
      imemload_exe = mk(0, 0, 0, 3'b001);
      #1 chk("bne_redirect", {31'd0, pc_redirect}, 32'd0);
      rdat1_exe = 32'hFFFF_FFFF; rdat2_exe = 32'd1; imemload_exe = mk(0, 0, 0, 3'b100);
      #1 chk("blt_redirect", {31'd0, pc_redirect}, 32'd1);
      imemload_exe = mk(0, 0, 0, 3'b110);
      #1 chk("bltu_redirect", {31'd0, pc_redirect}, 32'd0);
      step();
      clr(); imemaddr_exe = 32'h300; rdat1_exe = 32'h203; jalr_exe = 1; WEN_exe = 1;
      imemload_exe = mk(1, 0, 0, 0);
      #1 chk("jalr_redirect", {31'd0, pc_redirect}, 32'd1);
      chk("jalr_target", redirect_target, 32'h202);
      step();
      chk("jalr_npc", npc_mem, 32'h304);
      chk("jalr_jump", {31'd0, jump_mem}, 32'd1);

      // load handshake, with a flush request that arrives mid-stall
      clr(); imemaddr_exe = 32'h400; dmemr_exe = 1; WEN_exe = 1; memtoreg_exe = 1; ALUsrc_exe = 1;
      rdat1_exe = 32'h1000; imm_exe = 32'd8; imemload_exe = mk(2, 0, 0, 3'b010);
      step();
      for (int i = 0; i < 3; i++) begin
         clr(); alu(ALU_ADD, 32'd1, 32'd2, 5'd9); flush_in = (i == 1);
         #1 chk("ld_stall", {31'd0, stall}, 32'd1);
         chk("ld_ren", {31'd0, dmemREN}, 32'd1);
         chk("ld_addr", aluout_mem, 32'h1008);
         step();
      end
      clr(); alu(ALU_ADD, 32'd1, 32'd2, 5'd9); dhit = 1;
      #1 chk("ld_dhit_stall", {31'd0, stall}, 32'd0);
      step();
      chk("ld_ren_drop", {31'd0, dmemREN}, 32'd0);
      chk("ld_next", aluout_mem, 32'd3);

      // store retired while the front end is still waiting
      clr(); dmemw_exe = 1; ALUsrc_exe = 1; rdat1_exe = 32'h2000; imm_exe = 32'd4; rdat2_exe = 32'hDEAD_BEEF;
      step();
      chk("st_wen", {31'd0, dmemWEN}, 32'd1);
      chk("st_data", storedata_mem, 32'hDEAD_BEEF);
      clr(); alu(ALU_ADD, 32'd5, 32'd6, 5'd9); ihit = 0; dhit = 1;
      step();
      chk("st_wen_drop", {31'd0, dmemWEN}, 32'd0);
      chk("st_hold", aluout_mem, 32'h2004);
      ihit = 1; dhit = 0;
      step();
      chk("st_after", aluout_mem, 32'd11);

      // bubble
      clr(); alu(ALU_ADD, 32'd7, 32'd8, 5'd10); flush_in = 1;
      step();
      chk("flush_alu", aluout_mem, 32'd0);
      chk("flush_wen", {31'd0, WEN_mem}, 32'd0);

      // halt
      clr(); alu(ALU_ADD, 32'h77, 32'h0, 5'd12); halt_exe = 1;
      step();
      chk("halt_set", {31'd0, halt_mem}, 32'd1);
      clr(); alu(ALU_ADD, 32'd1, 32'd2, 5'd13); jal_exe = 1; imemaddr_exe = 32'h500; imm_exe = 32'h10;
      #1 chk("halt_no_redirect", {31'd0, pc_redirect}, 32'd0);
      step(); step();
      chk("halt_frozen", aluout_mem, 32'h77);
      chk("halt_sticky", {31'd0, halt_mem}, 32'd1);

      // asynchronous reset while a load request is outstanding
      #1 RST = 1;
      #1 RST = 0;
      clr(); dmemr_exe = 1; WEN_exe = 1; memtoreg_exe = 1; ALUsrc_exe = 1; imemaddr_exe = 32'h600;
      rdat1_exe = 32'h40; imm_exe = 32'd4; imemload_exe = mk(3, 0, 0, 3'b010);
      step();
      chk("pre_rst_ren", {31'd0, dmemREN}, 32'd1);
      #2 RST = 1;
      #1 chk("arst_ctrl", {26'd0, dmemREN, dmemWEN, WEN_mem, memtoreg_mem, jump_mem, halt_mem}, 32'd0);
      chk("arst_alu", aluout_mem, 32'd0);
      chk("arst_pc", imemaddr_mem | npc_mem, 32'd0);
      chk("arst_rd", {27'd0, rd_mem}, 32'd0);
      RST = 0;
      clr(); step();
      dhit = 1; step();

      // forwarding
      clr(); alu(ALU_ADD, 32'd3, 32'd4, 5'd5); step();
      chk("fwd_src", aluout_mem, 32'd7);
      clr(); alu(ALU_ADD, 32'd0, 32'd0, 5'd6); imemload_exe = mk(6, 5, 5, 0); step();
`ifdef EXE_FORWARD_EN
      chk("fwd_exmem", aluout_mem, 32'd14);
`else
      chk("nofwd_exmem", aluout_mem, 32'd0);
`endif
      clr(); alu(ALU_ADD, 32'd9, 32'd9, 5'd0); step();
      chk("x0_dest", aluout_mem, 32'd18);
      clr(); alu(ALU_ADD, 32'd1, 32'd1, 5'd8); step();
      chk("x0_nofwd", aluout_mem, 32'd2);
      clr(); alu(ALU_ADD, 32'd1, 32'd2, 5'd9); imemload_exe = mk(9, 7, 0, 0);
      wb_WEN = 1; wb_rd = 5'd7; wb_data = 32'd100; step();
`ifdef EXE_FORWARD_EN
      chk("fwd_wb", aluout_mem, 32'd102);
`else
      chk("nofwd_wb", aluout_mem, 32'd3);
`endif
      clr(); alu(ALU_ADD, 32'd1, 32'd0, 5'd11); imemload_exe = mk(11, 9, 0, 0);
      wb_WEN = 1; wb_rd = 5'd9; wb_data = 32'd500; step();
`ifdef EXE_FORWARD_EN
      chk("fwd_priority", aluout_mem, 32'd102);
`else
      chk("nofwd_priority", aluout_mem, 32'd1);
`endif

      clr(); step(); step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
